// File: rtl/softmax_pkg.sv
// Shared widths and FSM encoding for the softmax memory-side responder.
package softmax_pkg;

    localparam int DATAWIDTH = 16;
    localparam int NUM       = 2;
    localparam int ADDRSIZE  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_START,
        ST_RUN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/softmax_buf3r.sv
// Row buffer with one synchronous write port and NPORTS zero-latency read ports.
module softmax_buf3r
    import softmax_pkg::*;
#(
    parameter int WIDTH  = DATAWIDTH * NUM,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = ADDRSIZE,
    parameter int NPORTS = 3
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [ADDR_W-1:0]              wr_addr_i,
    input  logic [WIDTH-1:0]               wr_data_i,
    input  logic [NPORTS-1:0][ADDR_W-1:0]  rd_addr_i,
    output logic [NPORTS-1:0][WIDTH-1:0]   rd_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Out-of-range writes are discarded rather than aliased onto a low row.
    always_ff @(posedge clk) begin
        if (we_i && (wr_addr_i < DEPTH_A)) begin
            mem[wr_addr_i[AW-1:0]] <= wr_data_i;
        end
    end

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rd
            assign rd_data_o[gi] = (rd_addr_i[gi] < DEPTH_A) ? mem[rd_addr_i[gi][AW-1:0]] : '0;
        end
    endgenerate

endmodule

// File: rtl/softmax_mem_server.sv
// Memory-side responder: feeds the softmax engine from an input buffer,
// sequences init/start, and collects result pairs for host read-back.
module softmax_mem_server #(
    parameter int DATAWIDTH = softmax_pkg::DATAWIDTH,
    parameter int NUM       = softmax_pkg::NUM,
    parameter int ADDRSIZE  = softmax_pkg::ADDRSIZE,
    parameter int DEPTH     = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDRSIZE-1:0]       wr_addr,
    input  logic [DATAWIDTH*NUM-1:0]  wr_data,
    input  logic                      go,
    input  logic [ADDRSIZE-1:0]       len,
    output logic                      busy,
    output logic                      complete,
    output logic                      err,
    output logic                      init,
    output logic                      start,
    output logic [ADDRSIZE-1:0]       start_addr,
    output logic [ADDRSIZE-1:0]       end_addr,
    input  logic [ADDRSIZE-1:0]       addr,
    input  logic [ADDRSIZE-1:0]       sub0_inp_addr,
    input  logic [ADDRSIZE-1:0]       sub1_inp_addr,
    output logic [DATAWIDTH*NUM-1:0]  inp,
    output logic [DATAWIDTH*NUM-1:0]  sub0_inp,
    output logic [DATAWIDTH*NUM-1:0]  sub1_inp,
    input  logic                      res_valid,
    input  logic [DATAWIDTH-1:0]      outp0,
    input  logic [DATAWIDTH-1:0]      outp1,
    input  logic [ADDRSIZE-1:0]       rd_addr,
    output logic [DATAWIDTH*NUM-1:0]  rd_data
);

    import softmax_pkg::*;

    localparam int RW = DATAWIDTH * NUM;
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDRSIZE-1:0] DEPTH_A  = ADDRSIZE'(DEPTH);
    localparam logic [ADDRSIZE-1:0] ONE_A    = ADDRSIZE'(1);
    localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]       ONE_T    = TW'(1);

    state_t              state_q;
    logic                busy_q, complete_q, err_q, init_q, start_q;
    logic [ADDRSIZE-1:0] start_addr_q, end_addr_q, len_q, res_ptr_q;
    logic [TW-1:0]       tmo_q;

    logic                       buf_we;
    logic                       res_we;
    logic [2:0][ADDRSIZE-1:0]   rd_addr_vec;
    logic [2:0][RW-1:0]         rd_data_vec;
    logic [RW-1:0]              res_mem [DEPTH];

    // Host writes are only accepted between jobs so the engine never sees a row change mid-run.
    assign buf_we = wr_en && !busy_q;
    assign res_we = (state_q == ST_RUN) && res_valid && !reset;

    assign rd_addr_vec = {sub1_inp_addr, sub0_inp_addr, addr};

    softmax_buf3r #(
        .WIDTH  (RW),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDRSIZE),
        .NPORTS (3)
    ) u_inbuf (
        .clk       (clk),
        .we_i      (buf_we),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr_vec),
        .rd_data_o (rd_data_vec)
    );

    assign inp      = rd_data_vec[0];
    assign sub0_inp = rd_data_vec[1];
    assign sub1_inp = rd_data_vec[2];

    always_ff @(posedge clk) begin
        if (res_we) begin
            res_mem[res_ptr_q[AW-1:0]] <= RW'({outp1, outp0});
        end
    end

    assign rd_data = (rd_addr < DEPTH_A) ? res_mem[rd_addr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
            err_q        <= 1'b0;
            init_q       <= 1'b0;
            start_q      <= 1'b0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            len_q        <= '0;
            res_ptr_q    <= '0;
            tmo_q        <= '0;
        end else begin
            complete_q <= 1'b0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
            start_q    <= 1'b0;
            if (wr_en && busy_q) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        if (len == '0) begin
                            complete_q <= 1'b1;
                        end else if (len > DEPTH_A) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q        <= len;
                            end_addr_q   <= len;
                            start_addr_q <= '0;
                            res_ptr_q    <= '0;
                            tmo_q        <= '0;
                            init_q       <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    start_q <= 1'b1;
                    state_q <= ST_START;
                end
                ST_START: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    // A result arriving on the expiry cycle wins over the abort.
                    if (res_valid) begin
                        res_ptr_q <= res_ptr_q + ONE_A;
                        tmo_q     <= '0;
                        if ((res_ptr_q + ONE_A) == len_q) begin
                            complete_q <= 1'b1;
                            state_q    <= ST_FIN;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + ONE_T;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign complete   = complete_q;
    assign err        = err_q;
    assign init       = init_q;
    assign start      = start_q;
    assign start_addr = start_addr_q;
    assign end_addr   = end_addr_q;

endmodule
